fifo_byte_reader: RTL

//  Read-side drain engine for the capture FIFO, in the cwusb_clk domain. Pops 18-bit words

---
 rtl/fifo_byte_reader_if.sv | 31 +++
 rtl/fifo_byte_reader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fifo_byte_reader_if.sv
// Purpose: bundles the FIFO read port and the USB host byte-read port of fifo_byte_reader.
// Latency: n/a (wires only).
// Backpressure: n/a; the host paces reads with I_byte_rd, the FIFO is drained via O_fifo_read.
// Ports:
//   I_fifo_empty / I_fifo_data / O_fifo_read       : capture FIFO read side
//   I_byte_rd / I_flush / I_clear_flags            : host controls
//   O_byte / O_data_ready / O_underrun / O_words_read : host-visible status and data
// The slave modport is the drain engine; the master modport is its environment
// (FIFO plus USB register logic).
interface fifo_byte_reader_if;
  logic        I_fifo_empty;
  logic [17:0] I_fifo_data;
  logic        O_fifo_read;
  logic        I_byte_rd;
  logic        I_flush;
  logic        I_clear_flags;
  logic [7:0]  O_byte;
  logic        O_data_ready;
  logic        O_underrun;
  logic [31:0] O_words_read;

  modport slave (
    input  I_fifo_empty, I_fifo_data, I_byte_rd, I_flush, I_clear_flags,
    output O_fifo_read, O_byte, O_data_ready, O_underrun, O_words_read
  );

  modport master (
    output I_fifo_empty, I_fifo_data, I_byte_rd, I_flush, I_clear_flags,
    input  O_fifo_read, O_byte, O_data_ready, O_underrun, O_words_read
  );
endinterface

// File: rtl/fifo_byte_reader.sv
// Purpose: pops 18-bit capture words and serves them to the USB host as 3 bytes, LSB first.
// Latency: first byte valid FIFO_RD_LATENCY+1 cycles after the FIFO goes non-empty in IDLE.
// Backpressure: host paces with I_byte_rd; next word is popped on the 3rd-byte read.
// Ports:
//   cwusb_clk : the only clock
//   reset_n   : asynchronous active-low reset
//   bus       : fifo_byte_reader_if.slave (FIFO read port, host byte port, status)
module fifo_byte_reader #(
  parameter int         FIFO_RD_LATENCY = 1,      // 1..3
  parameter logic [7:0] PAD_BYTE        = 8'h00
) (
  input  logic          cwusb_clk,
  input  logic          reset_n,
  fifo_byte_reader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_LOADED = 2'd2
  } state_t;

  // Last WAIT cycle, in which I_fifo_data holds the popped word.
  localparam logic [1:0] LAT_LAST = 2'(FIFO_RD_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  lat_q, lat_d;
  logic [17:0] word_q, word_d;
  logic [31:0] words_q, words_d;
  logic        underrun_q, underrun_d;
  // Low during reset and for the first cycle after release, so no pop can be
  // issued while reset is asserted even if the FIFO is already non-empty.
  logic        run_q;
  logic        pop;
  logic        ready;

  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      lat_q      <= 2'd0;
      word_q     <= 18'd0;
      words_q    <= 32'd0;
      underrun_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      word_q     <= word_d;
      words_q    <= words_d;
      underrun_q <= underrun_d;
      run_q      <= 1'b1;
    end
  end

  assign ready = (state_q == S_LOADED);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    word_d     = word_q;
    words_d    = words_q;
    underrun_d = underrun_q;
    pop        = 1'b0;

    // Set beats clear when both land in the same cycle.
    if (bus.I_clear_flags)           underrun_d = 1'b0;
    if (bus.I_byte_rd && !ready)     underrun_d = 1'b1;

    if (bus.I_flush) begin
      // Any in-flight word is abandoned: leaving WAIT means I_fifo_data is never captured.
      state_d = S_IDLE;
      idx_d   = 2'd0;
      lat_d   = 2'd0;
      words_d = 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_q && !bus.I_fifo_empty) begin
            pop     = 1'b1;
            lat_d   = 2'd0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            word_d  = bus.I_fifo_data;
            idx_d   = 2'd0;
            state_d = S_LOADED;
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
        S_LOADED: begin
          if (bus.I_byte_rd) begin
            if (idx_q == 2'd2) begin
              words_d = words_q + 32'd1;
              idx_d   = 2'd0;
              // Prefetch: pop the next word in the same cycle the last byte goes out.
              if (!bus.I_fifo_empty) begin
                pop     = 1'b1;
                lat_d   = 2'd0;
                state_d = S_WAIT;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.O_byte = PAD_BYTE;
    if (ready) begin
      case (idx_q)
        2'd0:    bus.O_byte = word_q[7:0];
        2'd1:    bus.O_byte = word_q[15:8];
        default: bus.O_byte = {6'b0, word_q[17:16]};
      endcase
    end
  end

  assign bus.O_fifo_read  = pop;
  assign bus.O_data_ready = ready;
  assign bus.O_underrun   = underrun_q;
  assign bus.O_words_read = words_q;

endmodule
